// File: rtl/ball_round_ctrl.sv
// Game-level round sequencer for the three-ball breakout datapath.
// Tracks serve/play/miss/end states, live balls, lives and the one-shot multi-ball split.
module ball_round_ctrl #(
   parameter logic [1:0] LIVES        = 2'd3,
   parameter logic [7:0] SERVE_FRAMES = 8'd60,
   parameter logic [4:0] SPLIT_CNT    = 5'd1,
   parameter logic [4:0] TOTAL_BRICKS = 5'd20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       start,
   input  logic [2:0] miss,
   input  logic [4:0] collision_cnt,
   output logic [2:0] ball_en,
   output logic       freeze,
   output logic       serve,
   output logic       split,
   output logic [1:0] lives,
   output logic [2:0] state,
   output logic       game_over,
   output logic       win
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_MISS  = 3'd3,
      S_OVER  = 3'd4,
      S_WIN   = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ball_en_q, ball_en_d;
   logic       freeze_q, freeze_d;
   logic       serve_q, serve_d;
   logic       split_q, split_d;
   logic [1:0] lives_q, lives_d;
   logic       game_over_q, game_over_d;
   logic       win_q, win_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       split_done_q, split_done_d;
   logic       vsync_q, start_q;

   logic       frame_tick, start_rise;
   logic [2:0] en_n;

   // Falling vsync edge: the same instant the ball engine steps.
   assign frame_tick = vsync_q & ~vsync;
   assign start_rise = ~start_q & start;
   assign en_n       = ball_en_q & ~miss;

   always_comb begin
      state_d      = state_q;
      ball_en_d    = ball_en_q;
      lives_d      = lives_q;
      frame_cnt_d  = frame_cnt_q;
      split_done_d = split_done_q;
      serve_d      = 1'b0;
      split_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            ball_en_d    = 3'b001;
            split_done_d = 1'b0;
            if (start_rise) begin
               lives_d     = LIVES;
               frame_cnt_d = 8'd0;
               state_d     = S_SERVE;
            end
         end
         S_SERVE: begin
            ball_en_d = 3'b001;
            if (frame_tick) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               if (frame_cnt_q == SERVE_FRAMES - 8'd1) begin
                  serve_d = 1'b1;
                  state_d = S_PLAY;
               end
            end
         end
         S_PLAY: begin
            if (frame_tick) begin
               // Win beats miss, and losing the last ball beats the split.
               if (collision_cnt >= TOTAL_BRICKS) begin
                  state_d = S_WIN;
               end else if (en_n == 3'b000) begin
                  state_d = S_MISS;
               end else if (!split_done_q && (collision_cnt >= SPLIT_CNT) && en_n[0]) begin
                  ball_en_d    = 3'b111;
                  split_d      = 1'b1;
                  split_done_d = 1'b1;
               end else begin
                  ball_en_d = en_n;
               end
            end
         end
         S_MISS: begin
            if (lives_q <= 2'd1) begin
               lives_d = 2'd0;
               state_d = S_OVER;
            end else begin
               lives_d     = lives_q - 2'd1;
               ball_en_d   = 3'b001;
               frame_cnt_d = 8'd0;
               state_d     = S_SERVE;
            end
         end
         S_OVER, S_WIN: begin
            if (start_rise) begin
               ball_en_d = 3'b001;
               state_d   = S_IDLE;
            end
         end
         default: begin
            ball_en_d = 3'b001;
            state_d   = S_IDLE;
         end
      endcase

      freeze_d    = (state_d != S_PLAY);
      game_over_d = (state_d == S_OVER);
      win_d       = (state_d == S_WIN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ball_en_q    <= 3'b001;
         freeze_q     <= 1'b1;
         serve_q      <= 1'b0;
         split_q      <= 1'b0;
         lives_q      <= LIVES;
         game_over_q  <= 1'b0;
         win_q        <= 1'b0;
         frame_cnt_q  <= 8'd0;
         split_done_q <= 1'b0;
         vsync_q      <= 1'b0;
         start_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ball_en_q    <= ball_en_d;
         freeze_q     <= freeze_d;
         serve_q      <= serve_d;
         split_q      <= split_d;
         lives_q      <= lives_d;
         game_over_q  <= game_over_d;
         win_q        <= win_d;
         frame_cnt_q  <= frame_cnt_d;
         split_done_q <= split_done_d;
         vsync_q      <= vsync;
         start_q      <= start;
      end
   end

   assign ball_en   = ball_en_q;
   assign freeze    = freeze_q;
   assign serve     = serve_q;
   assign split     = split_q;
   assign lives     = lives_q;
   assign state     = state_q;
   assign game_over = game_over_q;
   assign win       = win_q;

endmodule

// File: tb/tb_ball_round_ctrl.sv
// Bench for ball_round_ctrl: vector table for a full game flow plus hand sequences
// for reset during a serve tick and reset mid-play.
module tb_ball_round_ctrl;

   localparam int W = 13;
   localparam logic [2:0] I  = 3'd0;
   localparam logic [2:0] SV = 3'd1;
   localparam logic [2:0] P  = 3'd2;
   localparam logic [2:0] M  = 3'd3;
   localparam logic [2:0] O  = 3'd4;
   localparam logic [2:0] WN = 3'd5;

   logic       clk = 1'b0;
   logic       reset, vsync, start;
   logic [2:0] miss;
   logic [4:0] collision_cnt;
   logic [2:0] ball_en;
   logic       freeze, serve, split, game_over, win;
   logic [1:0] lives;
   logic [2:0] state;

   always #5 clk = ~clk;

   ball_round_ctrl #(
      .LIVES(2'd3),
      .SERVE_FRAMES(8'd4),
      .SPLIT_CNT(5'd1),
      .TOTAL_BRICKS(5'd20)
   ) dut (
      .clk(clk),
      .reset(reset),
      .vsync(vsync),
      .start(start),
      .miss(miss),
      .collision_cnt(collision_cnt),
      .ball_en(ball_en),
      .freeze(freeze),
      .serve(serve),
      .split(split),
      .lives(lives),
      .state(state),
      .game_over(game_over),
      .win(win)
   );

   typedef struct {
      logic       rs;
      logic       st;
      logic       tk;
      logic [2:0] ms;
      logic [4:0] cc;
      logic [2:0] e_st;
      logic [2:0] e_ben;
      logic       e_fz;
      logic       e_sv;
      logic       e_sp;
      logic [1:0] e_lv;
      logic       ben_dc;
   } vec_t;

   vec_t         tbl[$];
   logic [W-1:0] exp_q[$];
   int           n_chk  = 0;
   int           n_pass = 0;

   function automatic vec_t mk(input logic rs, input logic st, input logic tk,
                               input logic [2:0] ms, input logic [4:0] cc,
                               input logic [2:0] e_st, input logic [2:0] e_ben,
                               input logic e_fz, input logic e_sv, input logic e_sp,
                               input logic [1:0] e_lv, input logic ben_dc);
      vec_t v;
      v.rs = rs; v.st = st; v.tk = tk; v.ms = ms; v.cc = cc;
      v.e_st = e_st; v.e_ben = e_ben; v.e_fz = e_fz; v.e_sv = e_sv;
      v.e_sp = e_sp; v.e_lv = e_lv; v.ben_dc = ben_dc;
      return v;
   endfunction

   function automatic logic [W-1:0] pk(input logic [2:0] st, input logic [2:0] ben,
                                       input logic fz, input logic sv, input logic sp,
                                       input logic [1:0] lv, input logic go, input logic wn);
      return {st, ben, fz, sv, sp, lv, go, wn};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic ben_dc);
      logic [W-1:0] exp_v, act_v, mask;
      exp_v = exp_q.pop_front();
      act_v = pk(state, ball_en, freeze, serve, split, lives, game_over, win);
      mask  = ben_dc ? 13'h1C7F : {W{1'b1}};
      n_chk++;
      if ((act_v & mask) == (exp_v & mask)) n_pass++;
      else $display("FAIL %s: got {st,ben,fz,sv,sp,lv,go,win}=%b required %b (mask %b)",
                    nm, act_v, exp_v, mask);
   endtask

   task automatic apply(input vec_t v, input string nm);
      start         = v.st;
      miss          = v.ms;
      collision_cnt = v.cc;
      exp_q.push_back(pk(v.e_st, v.e_ben, v.e_fz, v.e_sv, v.e_sp, v.e_lv,
                         v.e_st == O, v.e_st == WN));
      if (v.tk) begin
         vsync = 1'b1;
         cyc();
         vsync = 1'b0;
      end
      reset = v.rs;
      cyc();
      reset = 1'b0;
      check(nm, v.ben_dc);
   endtask

   initial begin
      reset = 1'b1; vsync = 1'b0; start = 1'b0; miss = 3'b000; collision_cnt = 5'd0;
      cyc();

      // reset state and a quiet cycle after release
      apply(mk(1,0,0,0,0, I,3'b001,1,0,0,3,0), "reset_hold");
      apply(mk(0,0,0,0,0, I,3'b001,1,0,0,3,0), "reset_idle");

      // game 1: serve, split, partial/full loss, game over
      tbl.push_back(mk(0,1,0,0,0, SV,3'b001,1,0,0,3,0));
      repeat (3) tbl.push_back(mk(0,0,1,0,0, SV,3'b001,1,0,0,3,0));
      tbl.push_back(mk(0,0,1,0,0, P,3'b001,0,1,0,3,0));
      tbl.push_back(mk(0,0,0,0,0, P,3'b001,0,0,0,3,0));
      tbl.push_back(mk(0,0,1,0,1, P,3'b111,0,0,1,3,0));
      tbl.push_back(mk(0,0,0,0,1, P,3'b111,0,0,0,3,0));
      tbl.push_back(mk(0,0,1,0,2, P,3'b111,0,0,0,3,0));
      tbl.push_back(mk(0,0,1,3'b010,2, P,3'b101,0,0,0,3,0));
      tbl.push_back(mk(0,0,1,3'b101,2, M,3'b000,1,0,0,3,1));
      tbl.push_back(mk(0,0,0,0,2, SV,3'b001,1,0,0,2,0));
      repeat (3) tbl.push_back(mk(0,0,1,0,2, SV,3'b001,1,0,0,2,0));
      tbl.push_back(mk(0,0,1,0,2, P,3'b001,0,1,0,2,0));
      tbl.push_back(mk(0,0,1,0,2, P,3'b001,0,0,0,2,0));
      tbl.push_back(mk(0,0,1,3'b001,2, M,3'b000,1,0,0,2,1));
      tbl.push_back(mk(0,0,0,0,2, SV,3'b001,1,0,0,1,0));
      repeat (3) tbl.push_back(mk(0,0,1,0,2, SV,3'b001,1,0,0,1,0));
      tbl.push_back(mk(0,0,1,0,2, P,3'b001,0,1,0,1,0));
      tbl.push_back(mk(0,0,1,3'b001,2, M,3'b000,1,0,0,1,1));
      tbl.push_back(mk(0,0,0,0,2, O,3'b000,1,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,2, O,3'b000,1,0,0,0,1));
      // start held high must not retrigger from IDLE
      tbl.push_back(mk(0,1,0,0,0, I,3'b001,1,0,0,0,0));
      repeat (2) tbl.push_back(mk(0,1,0,0,0, I,3'b001,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0, I,3'b001,1,0,0,0,0));
      // game 2: simultaneous win and full miss
      tbl.push_back(mk(0,1,0,0,0, SV,3'b001,1,0,0,3,0));
      repeat (3) tbl.push_back(mk(0,1,1,0,0, SV,3'b001,1,0,0,3,0));
      tbl.push_back(mk(0,1,1,0,0, P,3'b001,0,1,0,3,0));
      tbl.push_back(mk(0,1,1,3'b111,20, WN,3'b001,1,0,0,3,0));
      tbl.push_back(mk(0,1,0,0,20, WN,3'b001,1,0,0,3,0));
      tbl.push_back(mk(0,0,0,0,20, WN,3'b001,1,0,0,3,0));
      tbl.push_back(mk(0,1,0,0,0, I,3'b001,1,0,0,3,0));
      tbl.push_back(mk(0,0,0,0,0, I,3'b001,1,0,0,3,0));
      // game 3: losing the last ball beats the split
      tbl.push_back(mk(0,1,0,0,0, SV,3'b001,1,0,0,3,0));
      repeat (3) tbl.push_back(mk(0,0,1,0,0, SV,3'b001,1,0,0,3,0));
      tbl.push_back(mk(0,0,1,0,0, P,3'b001,0,1,0,3,0));
      tbl.push_back(mk(0,0,1,3'b001,1, M,3'b000,1,0,0,3,1));
      tbl.push_back(mk(0,0,0,0,1, SV,3'b001,1,0,0,2,0));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

      // reset on the launching frame tick suppresses the serve pulse
      for (int i = 0; i < 3; i++) apply(mk(0,0,1,0,0, SV,3'b001,1,0,0,2,0), "rst_serve_tick");
      apply(mk(1,0,1,0,0, I,3'b001,1,0,0,3,0), "rst_serve_hit");
      apply(mk(0,0,0,0,0, I,3'b001,1,0,0,3,0), "rst_serve_after");

      // play down to one life, split, then reset on a winning tick
      apply(mk(0,1,0,0,0, SV,3'b001,1,0,0,3,0), "mid_start");
      for (int k = 0; k < 2; k++) begin
         logic [1:0] lv;
         lv = 2'(3 - k);
         for (int i = 0; i < 3; i++) apply(mk(0,0,1,0,0, SV,3'b001,1,0,0,lv,0), "mid_serve");
         apply(mk(0,0,1,0,0, P,3'b001,0,1,0,lv,0), "mid_launch");
         apply(mk(0,0,1,3'b001,0, M,3'b000,1,0,0,lv,1), "mid_miss");
         apply(mk(0,0,0,0,0, SV,3'b001,1,0,0,lv - 2'd1,0), "mid_reserve");
      end
      for (int i = 0; i < 3; i++) apply(mk(0,0,1,0,0, SV,3'b001,1,0,0,1,0), "mid_serve1");
      apply(mk(0,0,1,0,0, P,3'b001,0,1,0,1,0), "mid_launch1");
      apply(mk(0,0,1,0,1, P,3'b111,0,0,1,1,0), "mid_split");
      apply(mk(1,0,1,0,20, I,3'b001,1,0,0,3,0), "mid_reset");
      apply(mk(0,0,0,0,0, I,3'b001,1,0,0,3,0), "mid_after");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ball_round_ctrl.md
# ball_round_ctrl

Round sequencer for the three-ball breakout datapath. It owns the game-level state (idle, serve, play, miss, game over, win). It gates which of the three balls are live, and freezes the ball engine between rounds. It issues serve and multi-ball split pulses and tracks remaining lives. It sits between the start button, the ball/collision logic and the VGA overlay that reads `state`, `lives`, `game_over` and `win`.

## Interface
Parameters:
- `LIVES`, 2'd3: lives loaded at game start; legal range 1..3.
- `SERVE_FRAMES`, 8'd60: frames held in SERVE before launch; legal range 1..255.
- `SPLIT_CNT`, 5'd1: brick-hit count that triggers the split to three balls.
- `TOTAL_BRICKS`, 5'd20: brick-hit count that ends the game as a win.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `vsync`, in, 1: VGA vsync, same domain as `clk`.
- `start`, in, 1: start button, level, already debounced.
- `miss`, in, 3: bit i high while ball i is at or below the bottom edge.
- `collision_cnt`, in, 5: cumulative brick hits this game.
- `ball_en`, out, 3: bit i high means ball i is live and drawn.
- `freeze`, out, 1: high means ball positions must hold.
- `serve`, out, 1: 1-cycle pulse meaning reload ball 0 to the serve position and launch.
- `split`, out, 1: 1-cycle pulse meaning copy ball 0 position into balls 1 and 2.
- `lives`, out, 2: remaining lives.
- `state`, out, 3: current state encoding.
- `game_over`, out, 1: high in OVER.
- `win`, out, 1: high in WIN.

## Operation
- `frame_tick` = `vsync` registered high and current `vsync` low. This is the 1→0 edge, the same instant the ball engine steps.
- `start_rise` = `start` registered low and current `start` high.
- State encodings: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, WIN=5. Codes 6 and 7 return to IDLE on the next cycle.
- **IDLE**:
  - `ball_en`=001, `freeze`=1, `split_done` cleared.
  - On `start_rise`: `lives`←`LIVES`, frame counter←0, go to SERVE.
- **SERVE**:
  - `ball_en`=001, `freeze`=1.
  - Frame counter increments on each `frame_tick`.
  - When the counter equals `SERVE_FRAMES`-1 and `frame_tick` is high: pulse `serve`, go to PLAY.
- **PLAY**: `freeze`=0. Evaluated only on `frame_tick`, in this priority order:
  1. `collision_cnt` ≥ `TOTAL_BRICKS` → go to WIN; `ball_en` unchanged.
  2. New enable set `en_n` = `ball_en` & ~`miss`. If `en_n`==000 → go to MISS.
  3. Otherwise, if `split_done`==0 and `collision_cnt` ≥ `SPLIT_CNT` and `en_n[0]`==1: `ball_en`←111, pulse `split`, set `split_done`. Otherwise `ball_en`←`en_n`.
- **MISS**:
  - Stays exactly 1 cycle, with `freeze`=1.
  - If `lives`==1: `lives`←0, go to OVER.
  - Otherwise: `lives`←`lives`-1, `ball_en`←001, frame counter←0, go to SERVE.
- **OVER / WIN**: `freeze`=1; `ball_en` holds its last value; on `start_rise`, go to IDLE.
- Split happens at most once per game. It does not re-arm after a lost life.
- `lives` is decremented only in MISS, so it never wraps below 0.

## Timing
- All outputs are registered and change on the `clk` edge after the causing condition.
- `serve` and `split` are high for exactly one `clk` cycle. They never assert together.
- Serve delay: from SERVE entry to the `serve` pulse is exactly `SERVE_FRAMES` frame ticks.
- Reset values:
  - `state`=IDLE, `ball_en`=001, `freeze`=1
  - `serve`=0, `split`=0, `lives`=`LIVES`
  - `game_over`=0, `win`=0, frame counter=0, `split_done`=0
  - edge registers=0
- Reset asserted mid-game is honoured on the next `clk` edge from any state, and overrides pending pulses.
- Simultaneous events on one `frame_tick`:
  - Win beats miss.
  - Miss of the last live ball beats split.
  - Misses on several balls in one tick are all cleared together.
- `start` held high does not retrigger. A new rising edge is required after OVER/WIN, and again from IDLE.

## Test plan
- **Reset, then serve and launch.** Stimulus: reset, `start` pulse, `SERVE_FRAMES`=4. Required: `state` goes 0→1; `serve` pulses 1 cycle after the 4th `frame_tick`; `state`=2, `freeze`=0, `lives`=3.
- **Split.** Stimulus: in PLAY, raise `collision_cnt` to 1. Required: on the next `frame_tick`, `ball_en`=111 and `split` is high for 1 cycle. Raising `collision_cnt` to 2 afterwards gives no second split.
- **Partial and full loss.** Stimulus: in PLAY with 111, assert `miss`=010, then 101 on the next tick. Required: `ball_en` goes 101, then MISS, `lives`=2, `state`=SERVE, `ball_en`=001.
- **Game over.** Stimulus: lose three serves with `LIVES`=3. Required: `lives` goes 2→1→0, `state`=OVER, `game_over`=1, `freeze`=1. `start_rise` returns to IDLE.
- **Simultaneous win and miss.** Stimulus: `collision_cnt`=20 and `miss`=111 on the same `frame_tick`. Required: `state`=WIN, `win`=1, `lives` unchanged.
- **Reset mid-play.** Stimulus: assert `reset` during PLAY with `ball_en`=111, `lives`=1. Required: next cycle `state`=IDLE, `ball_en`=001, `lives`=3, no `serve` or `split` pulse.
